qam_symbol_packer: RTL and testbench

QAM_SYMBOL_PACKER -- requirements
Module: qam_symbol_packer

---
 rtl/qam_symbol_packer_if.sv | 15 +
 rtl/qam_symbol_packer.sv | 123 ++++++++++++
 tb/tb_qam_symbol_packer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/qam_symbol_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : qam_symbol_packer_if
// Brief    : Byte stream handshake between the symbol packer and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface qam_symbol_packer_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface
`default_nettype wire

// File: rtl/qam_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module   : qam_symbol_packer
// Brief    : Samples demodulated QAM dibits once per symbol and packs four of
//            them MSB-first into bytes delivered through a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module qam_symbol_packer #(
    parameter int SPS          = 16,
    parameter int SAMPLE_PHASE = 15,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          clear,
    input  wire logic                          en,
    input  wire logic                          sym_sync,
    input  wire logic [1:0]                    data_demod,
    qam_symbol_packer_if.master                byte_if,
    output logic      [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                               overflow
);

    localparam int c_PW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_PW-1:0] c_LAST   = c_PW'(SPS - 1);
    localparam logic [c_PW-1:0] c_SAMPLE = c_PW'(SAMPLE_PHASE);
    localparam logic [c_AW:0]   c_FULL   = (c_AW + 1)'(FIFO_DEPTH);

    logic [c_PW-1:0] r_phase;
    logic [c_PW-1:0] w_eff_phase;
    logic [c_PW-1:0] w_phase_nxt;
    logic [1:0]      r_sym_cnt;
    logic [5:0]      r_partial;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_level;
    logic            r_overflow;

    logic            w_sample;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic            w_full;
    logic            w_write;
    logic            w_drop;
    logic [7:0]      w_byte;

    // sym_sync forces phase 0 for this cycle, so it also re-times sampling
    assign w_eff_phase = sym_sync ? '0 : r_phase;

    always_comb begin
        w_phase_nxt = r_phase;
        if (en || sym_sync) begin
            w_phase_nxt = (w_eff_phase == c_LAST) ? '0 : w_eff_phase + c_PW'(1);
        end
    end

    assign w_sample = en && !clear && (w_eff_phase == c_SAMPLE);
    assign w_push   = w_sample && (r_sym_cnt == 2'd3);
    assign w_byte   = {r_partial, data_demod};
    assign w_valid  = (r_level != '0);
    assign w_pop    = w_valid && byte_if.byte_ready && !clear;
    assign w_full   = (r_level == c_FULL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts it
    assign w_write  = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_sym_cnt  <= 2'd0;
            r_partial  <= 6'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_phase    <= '0;
            r_sym_cnt  <= 2'd0;
            r_partial  <= 6'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            if (w_sample) begin
                r_sym_cnt <= r_sym_cnt + 2'd1;
                r_partial <= {r_partial[3:0], data_demod};
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_write && !w_pop) begin
                r_level <= r_level + (c_AW + 1)'(1);
            end else if (w_pop && !w_write) begin
                r_level <= r_level - (c_AW + 1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    assign byte_if.byte_valid = w_valid;
    assign byte_if.byte_data  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_level         = r_level;
    assign overflow           = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_qam_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_symbol_packer
// Brief    : Directed self-checking bench for qam_symbol_packer (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_symbol_packer;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       en;
    logic       sym_sync;
    logic [1:0] data_demod;
    logic [2:0] fifo_level;
    logic       overflow;
    int         n_vec;
    int         n_bad;

    qam_symbol_packer_if bif ();

    qam_symbol_packer #(
        .SPS          (16),
        .SAMPLE_PHASE (15),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .en         (en),
        .sym_sync   (sym_sync),
        .data_demod (data_demod),
        .byte_if    (bif),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // One byte = four symbol periods, phase assumed 0 at the first cycle
    task automatic send_byte(input logic [7:0] b, input bit pop_last);
        en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            data_demod = b[7 - 2 * (i / 16) -: 2];
            if (i == 63 && pop_last) bif.byte_ready = 1'b1;
            tick();
        end
    endtask

    task automatic drain_check(input string tag, input logic [7:0] exp);
        check_val({tag, "_valid"}, 32'(bif.byte_valid), 32'd1);
        check_val({tag, "_data"}, 32'(bif.byte_data), 32'(exp));
        tick();
    endtask

    logic [7:0] pat;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        en = 1'b0;
        sym_sync = 1'b0;
        data_demod = 2'b00;
        bif.byte_ready = 1'b0;
        repeat (3) tick();

        check_val("rst_valid", 32'(bif.byte_valid), 32'd0);
        check_val("rst_data", 32'(bif.byte_data), 32'h00);
        check_val("rst_level", 32'(fifo_level), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Basic packing: 10,01,11,00 -> 8'h9C after cycle 63
        en = 1'b1;
        bif.byte_ready = 1'b1;
        pat = 8'h9C;
        for (int i = 0; i < 64; i++) begin
            sym_sync = (i == 0);
            data_demod = pat[7 - 2 * (i / 16) -: 2];
            if (i == 63) check_val("basic_early", 32'(bif.byte_valid), 32'd0);
            tick();
        end
        sym_sync = 1'b0;
        check_val("basic_valid", 32'(bif.byte_valid), 32'd1);
        check_val("basic_data", 32'(bif.byte_data), 32'h9C);
        check_val("basic_level", 32'(fifo_level), 32'd1);
        tick();
        check_val("basic_pulse", 32'(bif.byte_valid), 32'd0);

        // Overflow: five bytes into a 4-deep FIFO with no consumer
        bif.byte_ready = 1'b0;
        do_clear();
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        check_val("ovf_lvl4", 32'(fifo_level), 32'd4);
        check_val("ovf_pre", 32'(overflow), 32'd0);
        send_byte(8'hE5, 0);
        check_val("ovf_lvl5", 32'(fifo_level), 32'd4);
        check_val("ovf_set", 32'(overflow), 32'd1);
        en = 1'b0;
        bif.byte_ready = 1'b1;
        drain_check("ovf_d0", 8'hA1);
        drain_check("ovf_d1", 8'hB2);
        drain_check("ovf_d2", 8'hC3);
        drain_check("ovf_d3", 8'hD4);
        check_val("ovf_empty", 32'(bif.byte_valid), 32'd0);
        check_val("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a pop on the push cycle
        bif.byte_ready = 1'b0;
        do_clear();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 1);
        bif.byte_ready = 1'b0;
        check_val("full_lvl", 32'(fifo_level), 32'd4);
        check_val("full_ovf", 32'(overflow), 32'd0);
        en = 1'b0;
        bif.byte_ready = 1'b1;
        drain_check("full_d0", 8'h22);
        drain_check("full_d1", 8'h33);
        drain_check("full_d2", 8'h44);
        drain_check("full_d3", 8'h55);
        check_val("full_empty", 32'(bif.byte_valid), 32'd0);

        // sym_sync at phase 7 re-times sampling but keeps the symbol count
        do_clear();
        en = 1'b1;
        for (int i = 0; i < 71; i++) begin
            if (i < 16)       data_demod = 2'b11;
            else if (i < 38)  data_demod = 2'b00;
            else if (i == 38) data_demod = 2'b01;
            else if (i < 55)  data_demod = 2'b10;
            else              data_demod = 2'b11;
            sym_sync = (i == 23);
            if (i == 70) check_val("sync_early", 32'(bif.byte_valid), 32'd0);
            tick();
        end
        sym_sync = 1'b0;
        check_val("sync_valid", 32'(bif.byte_valid), 32'd1);
        check_val("sync_data", 32'(bif.byte_data), 32'hDB);

        // Reset mid-byte discards the two earlier samples
        do_clear();
        en = 1'b1;
        data_demod = 2'b11;
        repeat (32) tick();
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(bif.byte_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        send_byte(8'h36, 0);
        check_val("arst_byte", 32'(bif.byte_valid), 32'd1);
        check_val("arst_data", 32'(bif.byte_data), 32'h36);
        check_val("arst_level", 32'(fifo_level), 32'd1);
        tick();
        check_val("arst_once", 32'(bif.byte_valid), 32'd0);

        // Clear with three bytes buffered and overflow set
        bif.byte_ready = 1'b0;
        do_clear();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h05, 0);
        en = 1'b0;
        bif.byte_ready = 1'b1;
        tick();
        bif.byte_ready = 1'b0;
        check_val("clr_pre_lvl", 32'(fifo_level), 32'd3);
        check_val("clr_pre_ovf", 32'(overflow), 32'd1);
        do_clear();
        check_val("clr_valid", 32'(bif.byte_valid), 32'd0);
        check_val("clr_level", 32'(fifo_level), 32'd0);
        check_val("clr_ovf", 32'(overflow), 32'd0);
        check_val("clr_data", 32'(bif.byte_data), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
